// File: rtl/nfc_pkg.sv
// Shared types, command codes and the op-to-command mapping for the NAND host sequencer.
package nfc_pkg;

  typedef enum logic [1:0] {
    OP_PROGRAM = 2'b00,
    OP_READ    = 2'b01,
    OP_ERASE   = 2'b10,
    OP_RESET   = 2'b11
  } op_e;

  localparam logic [2:0] NFC_CMD_NONE    = 3'b000;
  localparam logic [2:0] NFC_CMD_PROGRAM = 3'b001;
  localparam logic [2:0] NFC_CMD_READ    = 3'b010;
  localparam logic [2:0] NFC_CMD_RESET   = 3'b011;
  localparam logic [2:0] NFC_CMD_ERASE   = 3'b100;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_CMD_ERR = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  function automatic logic [2:0] op_to_cmd(input op_e op);
    logic [2:0] cmd;
    case (op)
      OP_PROGRAM: cmd = NFC_CMD_PROGRAM;
      OP_READ:    cmd = NFC_CMD_READ;
      OP_ERASE:   cmd = NFC_CMD_ERASE;
      OP_RESET:   cmd = NFC_CMD_RESET;
      default:    cmd = NFC_CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/nfc_skid_fifo.sv
// Two-entry skid FIFO that decouples buffer read latency from read-port backpressure.
module nfc_skid_fifo #(
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] pop_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign do_pop_s   = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the same cycle pops.
  assign do_push_s  = push_i && (!full_o || do_pop_s);
  assign pop_data_o = empty_o ? {DataWidth{1'b0}} : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q[0] <= {DataWidth{1'b0}};
      mem_q[1] <= {DataWidth{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

endmodule

// File: rtl/nfc_host_sequencer.sv
// Host-side page command sequencer: fills the controller page buffer, issues one command,
// waits for completion, drains read data through a skid FIFO and returns one status per request.
module nfc_host_sequencer
  import nfc_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 18,
  parameter int PageWords     = 1024,
  parameter int TimeoutCycles = 65535
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DataWidth-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DataWidth-1:0] rd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic                 buf_sel,
  output logic                 buf_we,
  output logic                 buf_re,
  output logic [DataWidth-1:0] buf_in,
  input  logic [DataWidth-1:0] buf_out,
  output logic [2:0]           nfc_cmd,
  output logic [AddrWidth-1:0] RWA,
  output logic                 nfc_start,
  input  logic                 nfc_done,
  input  logic                 command_error
);

  localparam int CntW  = $clog2(PageWords + 1);
  localparam int WaitW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0]  LastWord  = CntW'(PageWords - 1);
  localparam logic [CntW-1:0]  PageCnt   = CntW'(PageWords);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(TimeoutCycles);
  localparam logic [WaitW-1:0] WaitMax   = {WaitW{1'b1}};

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  status_e              status_q, status_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [CntW-1:0]      wcnt_q, wcnt_d;
  logic [CntW-1:0]      iss_q, iss_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic                 inflight_q;

  logic                 wr_fire_s;
  logic                 rd_pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [1:0]           occ_s;
  logic [2:0]           pending_s;
  logic [WaitW-1:0]     wait_inc_s;

  assign req_ready  = (state_q == S_IDLE);
  assign wr_ready   = (state_q == S_FILL);
  assign wr_fire_s  = wr_valid && wr_ready;
  assign buf_we     = wr_fire_s;
  assign buf_in     = wr_fire_s ? wr_data : {DataWidth{1'b0}};
  assign buf_sel    = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign nfc_start  = (state_q == S_START);
  assign nfc_cmd    = ((state_q == S_START) || (state_q == S_WAIT)) ? op_to_cmd(op_q) : NFC_CMD_NONE;
  assign RWA        = addr_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_status = rsp_valid ? status_q : ST_OK;
  assign rd_valid   = !fifo_empty_s;
  assign rd_pop_s   = rd_valid && rd_ready;
  assign wait_inc_s = wait_q + {{(WaitW-1){1'b0}}, 1'b1};

  // Occupancy after this cycle's pop plus the read in flight; counting the pop keeps the
  // port gap-free at one word per cycle while never overrunning the two entries.
  assign occ_s     = fifo_full_s ? 2'd2 : (fifo_empty_s ? 2'd0 : 2'd1);
  assign pending_s = {1'b0, occ_s} - {2'b00, rd_pop_s} + {2'b00, inflight_q};
  assign buf_re    = (state_q == S_DRAIN) && (pending_s < 3'd2) && (iss_q < PageCnt);

  nfc_skid_fifo #(
    .DataWidth (DataWidth)
  ) u_skid (
    .clk_i       (clk),
    .reset_i     (Reset),
    .push_i      (inflight_q),
    .push_data_i (buf_out),
    .pop_i       (rd_pop_s),
    .pop_data_o  (rd_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PROGRAM;
      status_q   <= ST_OK;
      addr_q     <= {AddrWidth{1'b0}};
      wcnt_q     <= {CntW{1'b0}};
      iss_q      <= {CntW{1'b0}};
      wait_q     <= {WaitW{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      iss_q      <= iss_d;
      wait_q     <= wait_d;
      inflight_q <= buf_re;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = status_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    iss_d    = iss_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d     = op_e'(req_op);
          addr_d   = req_addr;
          status_d = ST_OK;
          wcnt_d   = {CntW{1'b0}};
          iss_d    = {CntW{1'b0}};
          wait_d   = {WaitW{1'b0}};
          state_d  = (op_e'(req_op) == OP_PROGRAM) ? S_FILL : S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (wr_fire_s && (wcnt_q == LastWord)) begin
          wcnt_d  = {CntW{1'b0}};
          state_d = S_START;
        end else if (wr_fire_s) begin
          wcnt_d = wcnt_q + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_START: begin
        wait_d  = {WaitW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An error reported alongside done takes precedence over the completion.
        if (command_error) begin
          status_d = ST_CMD_ERR;
          state_d  = S_RESP;
        end else if (nfc_done && (op_q == OP_READ)) begin
          wcnt_d  = {CntW{1'b0}};
          iss_d   = {CntW{1'b0}};
          state_d = S_DRAIN;
        end else if (nfc_done) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if ((TimeoutCycles != 0) && (wait_inc_s == WaitLimit)) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          wait_d = (wait_q == WaitMax) ? wait_q : wait_inc_s;
        end
      end
      S_DRAIN: begin
        if (buf_re) begin
          iss_d = iss_q + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
          iss_d = iss_q;
        end
        if (rd_pop_s && (wcnt_q == LastWord)) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (rd_pop_s) begin
          wcnt_d = wcnt_q + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nfc_host_sequencer.sv
// Directed self-checking bench for nfc_host_sequencer with a one-cycle-latency page buffer model.
module tb_nfc_host_sequencer;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int PW = 1024;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          Reset;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_status;
  logic          buf_sel, buf_we, buf_re;
  logic [DW-1:0] buf_in;
  logic [DW-1:0] buf_out = 16'h0000;
  logic [2:0]    nfc_cmd;
  logic [AW-1:0] RWA;
  logic          nfc_start, nfc_done, command_error;

  int tests = 0;
  int fails = 0;

  // Counters maintained by monitors; the initial block only snapshots them via *_base.
  int wr_idx = 0, wr_base = 0;
  int we_idx = 0, we_base = 0, we_err = 0;
  int re_idx = 0, re_base = 0;
  int rd_idx = 0, rd_base = 0, rd_err = 0;
  int start_cnt = 0, act_cnt = 0, cyc = 0;
  int first_cyc = 0, last_cyc = 0;

  nfc_host_sequencer #(
    .DataWidth (DW), .AddrWidth (AW), .PageWords (PW), .TimeoutCycles (TO)
  ) dut (
    .clk (clk), .Reset (Reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_op (req_op), .req_addr (req_addr),
    .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data),
    .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_status (rsp_status),
    .buf_sel (buf_sel), .buf_we (buf_we), .buf_re (buf_re), .buf_in (buf_in), .buf_out (buf_out),
    .nfc_cmd (nfc_cmd), .RWA (RWA), .nfc_start (nfc_start),
    .nfc_done (nfc_done), .command_error (command_error)
  );

  always #5 clk = ~clk;

  assign wr_data = 16'(wr_idx - wr_base);

  always @(posedge clk) begin
    if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
    if (buf_re) begin
      buf_out <= 16'hA000 + 16'(re_idx - re_base);
      re_idx  <= re_idx + 1;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (buf_we) begin
      if (buf_in !== 16'(we_idx - we_base)) we_err <= we_err + 1;
      we_idx <= we_idx + 1;
    end
    if (nfc_start) start_cnt <= start_cnt + 1;
    if (buf_sel || buf_re || buf_we) act_cnt <= act_cnt + 1;
    if (rd_valid && rd_ready) begin
      if (rd_data !== 16'hA000 + 16'(rd_idx - rd_base)) rd_err <= rd_err + 1;
      if (rd_idx == rd_base) first_cyc <= cyc;
      last_cyc <= cyc;
      rd_idx   <= rd_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [2:0] cmd, input logic [AW-1:0] addr);
    int n = 0;
    while (!nfc_start && n < 3000) begin tick(); n++; end
    chk({tag, "_start"}, {31'd0, nfc_start}, 32'd1);
    chk({tag, "_cmd"}, {29'd0, nfc_cmd}, {29'd0, cmd});
    chk({tag, "_rwa"}, {14'd0, RWA}, {14'd0, addr});
  endtask

  task automatic pulse_done(input int delay, input logic done, input logic err);
    repeat (delay) tick();
    nfc_done = done; command_error = err;
    tick();
    nfc_done = 1'b0; command_error = 1'b0;
  endtask

  task automatic finish_rsp(input string tag, input logic [1:0] exp_st, input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin tick(); n++; end
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_status"}, {30'd0, rsp_status}, {30'd0, exp_st});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, s0, a0;
    Reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 18'h00000;
    wr_valid = 1'b0; rd_ready = 1'b0; rsp_ready = 1'b0;
    nfc_done = 1'b0; command_error = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outputs", {24'd0, rsp_valid, buf_sel, buf_we, buf_re, nfc_start, rd_valid, wr_ready, 1'b0}, 32'd0);
    chk("rst_cmd_rwa", {11'd0, nfc_cmd, RWA}, 32'd0);
    Reset = 1'b0;
    tick();

    // Program: 1024-word ramp, done 50 cycles after START.
    wr_base = wr_idx; we_base = we_idx; s0 = start_cnt;
    wr_valid = 1'b1;
    do_req(2'b00, 18'h00123);
    wait_start("prog", 3'b001, 18'h00123);
    wr_valid = 1'b0;
    chk("prog_we_count", we_idx - we_base, 32'd1024);
    pulse_done(50, 1'b1, 1'b0);
    finish_rsp("prog", 2'b00, 200);
    chk("prog_we_data_err", we_err, 32'd0);
    chk("prog_start_count", start_cnt - s0, 32'd1);

    // Read with random backpressure including a long stall.
    rd_base = rd_idx; re_base = re_idx;
    do_req(2'b01, 18'h00040);
    wait_start("read", 3'b010, 18'h00040);
    pulse_done(10, 1'b1, 1'b0);
    n = 0;
    while (!rsp_valid && n < 10000) begin
      rd_ready = (n >= 100 && n < 160) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rd_ready = 1'b0;
    finish_rsp("read_rand", 2'b00, 10);
    chk("read_rand_count", rd_idx - rd_base, 32'd1024);
    chk("read_rand_re_count", re_idx - re_base, 32'd1024);
    chk("read_rand_data_err", rd_err, 32'd0);

    // Read with rd_ready held high: 1024 words on consecutive cycles.
    rd_base = rd_idx; re_base = re_idx;
    rd_ready = 1'b1;
    do_req(2'b01, 18'h00041);
    wait_start("read_b2b", 3'b010, 18'h00041);
    pulse_done(5, 1'b1, 1'b0);
    finish_rsp("read_b2b", 2'b00, 3000);
    rd_ready = 1'b0;
    chk("read_b2b_count", rd_idx - rd_base, 32'd1024);
    chk("read_b2b_span", last_cyc - first_cyc, 32'd1023);
    chk("read_b2b_data_err", rd_err, 32'd0);

    // Erase rejected by the controller.
    a0 = act_cnt;
    do_req(2'b10, 18'h00777);
    wait_start("erase", 3'b100, 18'h00777);
    pulse_done(5, 1'b0, 1'b1);
    finish_rsp("erase", 2'b01, 50);
    chk("erase_no_buf_activity", act_cnt - a0, 32'd0);
    chk("erase_then_ready", {31'd0, req_ready}, 32'd1);

    // Reset op with no completion: 100 WAIT cycles, RESP visible on the 101st cycle after START.
    do_req(2'b11, 18'h00005);
    wait_start("timeout", 3'b011, 18'h00005);
    n = 0;
    while (!rsp_valid && n < 500) begin tick(); n++; end
    chk("timeout_cycles", n, 32'd101);
    finish_rsp("timeout", 2'b10, 5);

    // Read with done and error together: error wins, nothing drained.
    rd_base = rd_idx; re_base = re_idx;
    rd_ready = 1'b1;
    do_req(2'b01, 18'h00042);
    wait_start("both", 3'b010, 18'h00042);
    pulse_done(3, 1'b1, 1'b1);
    finish_rsp("both", 2'b01, 50);
    rd_ready = 1'b0;
    chk("both_no_reads", (rd_idx - rd_base) + (re_idx - re_base), 32'd0);

    // Reset during FILL at word 500, then a fresh program.
    wr_base = wr_idx; we_base = we_idx; s0 = start_cnt;
    wr_valid = 1'b1;
    do_req(2'b00, 18'h00200);
    n = 0;
    while ((wr_idx - wr_base) < 500 && n < 2000) begin tick(); n++; end
    chk("abort_fill_500", wr_idx - wr_base, 32'd500);
    Reset = 1'b1;
    tick();
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_strobes", {26'd0, buf_sel, buf_we, buf_re, nfc_start, rsp_valid, rd_valid}, 32'd0);
    Reset = 1'b0;
    wr_valid = 1'b0;
    tick();
    chk("abort_no_start", start_cnt - s0, 32'd0);

    wr_base = wr_idx; we_base = we_idx; s0 = start_cnt;
    wr_valid = 1'b1;
    do_req(2'b00, 18'h00300);
    wait_start("prog2", 3'b001, 18'h00300);
    wr_valid = 1'b0;
    chk("prog2_we_count", we_idx - we_base, 32'd1024);
    pulse_done(20, 1'b1, 1'b0);
    finish_rsp("prog2", 2'b00, 200);
    chk("prog2_we_data_err", we_err, 32'd0);
    chk("prog2_start_count", start_cnt - s0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
